// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer: stall bus encoding,
// stall-level masks, sub-sequencer state enums and the debug snapshot struct.
package pipe_ctrl_pkg;

  localparam int StallBus = 6;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int DIV_CYCLES_DEF = 33;
  localparam int CNT_W_DEF      = 6;

  // Level k stops stages 0..k (PC upward) and lets the rest drain.
  function automatic logic [StallBus-1:0] level_mask(input int top);
    logic [StallBus-1:0] m;
    m = {StallBus{NoStop}};
    for (int i = 0; i < StallBus; i++) begin
      if (i <= top) m[i] = Stop;
    end
    return m;
  endfunction

  localparam logic [StallBus-1:0] STALL_NONE    = {StallBus{NoStop}};
  localparam logic [StallBus-1:0] STALL_LOADUSE = level_mask(2);
  localparam logic [StallBus-1:0] STALL_DIV     = level_mask(3);
  localparam logic [StallBus-1:0] STALL_MEM     = level_mask(4);

  typedef enum logic {DIV_IDLE, DIV_RUN}  div_state_e;
  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_e;

  typedef struct packed {
    div_state_e             div_state;
    mem_state_e             mem_state;
    logic [CNT_W_DEF-1:0]   div_cnt;
    logic                   flush_pend;
  } dbg_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/stall bundle between the pipeline stages and pipe_ctrl.
// mem_req/mem_ack: mem_req is sampled only while the memory FSM is idle; the
// access is done in the cycle mem_ack is high (same-cycle ack means no wait).
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                id_stallreq;
  logic                ex_div_start;
  logic                mem_req;
  logic                mem_ack;
  logic                flush_req;
  logic [StallBus-1:0] stall;
  logic                flush;
  logic                div_busy;
  logic                div_done;
  dbg_t                dbg;

  modport master (
    output id_stallreq, ex_div_start, mem_req, mem_ack, flush_req,
    input  stall, flush, div_busy, div_done, dbg
  );

  modport slave (
    input  id_stallreq, ex_div_start, mem_req, mem_ack, flush_req,
    output stall, flush, div_busy, div_done, dbg
  );
endinterface

// File: rtl/pipe_ctrl_divseq.sv
// Divider occupancy sequencer: counts EX-hold cycles of a div/divu, freezing
// while MEM is waiting, and pulses done_o in the release cycle.
module pipe_ctrl_divseq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             freeze_i,
  input  logic             abort_i,
  output logic             level_o,
  output logic             busy_o,
  output logic             done_o,
  output div_state_e       state_o,
  output logic [CNT_W-1:0] cnt_o
);

  // Start cycle plus the release cycle account for the two cycles not counted.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = DIV_RUN;
          cnt_d   = CNT_LOAD;
          level_o = 1'b1;
        end
      end
      DIV_RUN: begin
        if (abort_i) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else if (freeze_i) begin
          level_o = 1'b1;
        end else if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = DIV_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          level_o = 1'b1;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o  = (state_q == DIV_RUN);
  assign state_o = state_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges load-use, divider and memory-wait stall levels
// into the 6-bit stall bus and issues flushes once MEM is not waiting.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave ctrl
);

  mem_state_e       mem_q, mem_d;
  logic             flush_pend_q, flush_pend_d;
  logic             mem_lvl;
  logic             flush_now;
  logic             div_lvl;
  div_state_e       div_state;
  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q        <= MEM_IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    mem_d   = mem_q;
    mem_lvl = 1'b0;
    unique case (mem_q)
      MEM_IDLE: begin
        if (ctrl.mem_req && !ctrl.mem_ack) begin
          mem_d   = MEM_WAIT;
          mem_lvl = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (ctrl.mem_ack) mem_d   = MEM_IDLE;
        else              mem_lvl = 1'b1;
      end
      default: mem_d = MEM_IDLE;
    endcase
  end

  // A flush cannot discard MEM mid-access, so it is held until the ack cycle.
  assign flush_now = (ctrl.flush_req || flush_pend_q) && !mem_lvl;

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flush_now)                        flush_pend_d = 1'b0;
    else if (ctrl.flush_req && mem_lvl)   flush_pend_d = 1'b1;
  end

  pipe_ctrl_divseq #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_divseq (
    .clk      (clk),
    .rst      (rst),
    .start_i  (ctrl.ex_div_start),
    .freeze_i (mem_lvl),
    .abort_i  (flush_now),
    .level_o  (div_lvl),
    .busy_o   (ctrl.div_busy),
    .done_o   (ctrl.div_done),
    .state_o  (div_state),
    .cnt_o    (div_cnt)
  );

  always_comb begin
    ctrl.stall = STALL_NONE;
    if (flush_now)             ctrl.stall = STALL_NONE;
    else if (mem_lvl)          ctrl.stall = STALL_MEM;
    else if (div_lvl)          ctrl.stall = STALL_DIV;
    else if (ctrl.id_stallreq) ctrl.stall = STALL_LOADUSE;
  end

  assign ctrl.flush = flush_now;

  assign ctrl.dbg.div_state  = div_state;
  assign ctrl.dbg.mem_state  = mem_q;
  assign ctrl.dbg.div_cnt    = CNT_W_DEF'(div_cnt);
  assign ctrl.dbg.flush_pend = flush_pend_q;

endmodule
